// File: rtl/store_narrow.sv
// Store-path narrowing unit: issues a 32-bit halfword/word store as one or two 16-bit write beats, low half first.
// Optional halfword truncation flag enabled by defining STORE_NARROW_TRUNC_CHECK_EN.
module store_narrow #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic              req_size,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic              mem_ack,
    output logic              done,
    output logic              trunc_err
);

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI
    } state_t;

    state_t      state;
    logic [15:0] data_hi;
    logic        size_word;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            mem_wr_en <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            done      <= 1'b0;
            data_hi   <= '0;
            size_word <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        state     <= LO;
                        req_ready <= 1'b0;
                        mem_wr_en <= 1'b1;
                        mem_addr  <= {req_addr[ADDR_W-1:1], 1'b0};
                        mem_wdata <= req_data[15:0];
                        data_hi   <= req_data[31:16];
                        size_word <= req_size;
                    end
                end
                LO: begin
                    if (mem_ack) begin
                        if (size_word) begin
                            // mem_addr still holds the base; the carry out of the top bit is dropped.
                            state     <= HI;
                            mem_addr  <= mem_addr + ADDR_W'(2);
                            mem_wdata <= data_hi;
                        end else begin
                            state     <= IDLE;
                            mem_wr_en <= 1'b0;
                            req_ready <= 1'b1;
                            done      <= 1'b1;
                        end
                    end
                end
                HI: begin
                    if (mem_ack) begin
                        state     <= IDLE;
                        mem_wr_en <= 1'b0;
                        req_ready <= 1'b1;
                        done      <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_wr_en <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef STORE_NARROW_TRUNC_CHECK_EN
    // Flags the accept of a halfword whose upper bits would be silently dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            trunc_err <= 1'b0;
        end else begin
            trunc_err <= (state == IDLE) && req_valid && !req_size && (req_data[31:16] != 16'h0);
        end
    end
`else
    assign trunc_err = 1'b0;
`endif

endmodule

// File: tb/tb_store_narrow.sv
// Self-checking bench for store_narrow: directed scenarios plus randomized stores against a beat-list model.
module tb_store_narrow;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        req_size;
    logic        mem_wr_en;
    logic [31:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic        done;
    logic        trunc_err;

    int checks   = 0;
    int failures = 0;

    store_narrow #(.ADDR_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_size  (req_size),
        .mem_wr_en (mem_wr_en),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .done      (done),
        .trunc_err (trunc_err)
    );

    always #5 clk = ~clk;

    function automatic logic exp_trunc(input logic [31:0] d, input logic s);
`ifdef STORE_NARROW_TRUNC_CHECK_EN
        return !s && (d[31:16] != 16'h0);
`else
        return 1'b0;
`endif
    endfunction

    // Drives one store starting at a negedge and checks every cycle up to and including the done cycle.
    // Returns at the negedge of the done cycle, so a following call is a back-to-back request.
    task automatic run_store(input string name, input logic [31:0] a, input logic [31:0] d,
                             input logic s, input int dly);
        logic [31:0] b_addr [2];
        logic [15:0] b_data [2];
        int          nbeats;
        logic        tr;
        b_addr[0] = a & 32'hFFFF_FFFE;
        b_data[0] = d[15:0];
        b_addr[1] = b_addr[0] + 32'd2;
        b_data[1] = d[31:16];
        nbeats    = s ? 2 : 1;
        tr        = exp_trunc(d, s);

        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s ready_at_accept got=%b exp=1", name, req_ready);
        end
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        req_size  = s;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_data  = $urandom;
        req_size  = 1'($urandom);

        for (int b = 0; b < nbeats; b++) begin
            for (int c = 0; c <= dly; c++) begin
                checks++;
                if (mem_wr_en !== 1'b1 || mem_addr !== b_addr[b] || mem_wdata !== b_data[b] ||
                    done !== 1'b0 || req_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL %s beat%0d cyc%0d got en=%b addr=%h data=%h done=%b rdy=%b exp en=1 addr=%h data=%h done=0 rdy=0",
                             name, b, c, mem_wr_en, mem_addr, mem_wdata, done, req_ready, b_addr[b], b_data[b]);
                end
                checks++;
                if (trunc_err !== ((b == 0 && c == 0) ? tr : 1'b0)) begin
                    failures++;
                    $display("FAIL %s trunc_err beat%0d cyc%0d got=%b exp=%b", name, b, c, trunc_err,
                             (b == 0 && c == 0) ? tr : 1'b0);
                end
                mem_ack = (c == dly);
                @(negedge clk);
            end
        end
        mem_ack = 1'b0;
        checks++;
        if (done !== 1'b1 || req_ready !== 1'b1 || mem_wr_en !== 1'b0) begin
            failures++;
            $display("FAIL %s done_cycle got done=%b rdy=%b en=%b exp done=1 rdy=1 en=0",
                     name, done, req_ready, mem_wr_en);
        end
    endtask

    task automatic idle_cycles(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            mem_ack = 1'($urandom);
            @(negedge clk);
            checks++;
            if (mem_wr_en !== 1'b0 || done !== 1'b0 || req_ready !== 1'b1 || trunc_err !== 1'b0) begin
                failures++;
                $display("FAIL %s idle got en=%b done=%b rdy=%b trunc=%b exp en=0 done=0 rdy=1 trunc=0",
                         name, mem_wr_en, done, req_ready, trunc_err);
            end
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        req_addr = '0;
        req_data = '0;
        req_size = 1'b0;
        mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || mem_wr_en !== 1'b0 || mem_addr !== 32'h0 ||
            mem_wdata !== 16'h0 || done !== 1'b0 || trunc_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_values got rdy=%b en=%b addr=%h data=%h done=%b trunc=%b exp 1 0 0 0 0 0",
                     req_ready, mem_wr_en, mem_addr, mem_wdata, done, trunc_err);
        end
        rst = 1'b0;
        // Stray acks while idle must not start anything.
        idle_cycles("ack_while_idle", 4);
    endtask

    task automatic test_halfword();
        run_store("half_basic", 32'h0000_0100, 32'h0000_BEEF, 1'b0, 0);
        idle_cycles("half_basic_after", 1);
    endtask

    task automatic test_word_delayed();
        run_store("word_delayed", 32'h0000_0200, 32'h1234_5678, 1'b1, 2);
        idle_cycles("word_delayed_after", 2);
    endtask

    task automatic test_addr_edges();
        run_store("word_wrap", 32'hFFFF_FFFE, 32'hCAFE_F00D, 1'b1, 0);
        idle_cycles("word_wrap_after", 1);
        run_store("word_odd", 32'h0000_0301, 32'hA5A5_5A5A, 1'b1, 1);
        idle_cycles("word_odd_after", 1);
    endtask

    task automatic test_back_to_back();
        run_store("b2b_word", 32'h0000_0400, 32'h1111_2222, 1'b1, 0);
        run_store("b2b_half", 32'h0000_0410, 32'h0000_3333, 1'b0, 0);
        idle_cycles("b2b_after", 2);
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1;
        req_addr  = 32'h0000_0500;
        req_data  = 32'h7777_8888;
        req_size  = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        mem_ack   = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        checks++;
        if (mem_wr_en !== 1'b1 || mem_addr !== 32'h0000_0502 || mem_wdata !== 16'h7777) begin
            failures++;
            $display("FAIL rst_mid_hi_beat got en=%b addr=%h data=%h exp en=1 addr=00000502 data=7777",
                     mem_wr_en, mem_addr, mem_wdata);
        end
        @(negedge clk);
        rst       = 1'b1;
        mem_ack   = 1'b1;
        req_valid = 1'b1;
        req_size  = 1'b0;
        @(negedge clk);
        rst       = 1'b0;
        mem_ack   = 1'b0;
        req_valid = 1'b0;
        checks++;
        if (mem_wr_en !== 1'b0 || done !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_abandon got en=%b done=%b rdy=%b exp en=0 done=0 rdy=1",
                     mem_wr_en, done, req_ready);
        end
        idle_cycles("rst_mid_after", 2);
        run_store("rst_mid_next", 32'h0000_0600, 32'h9ABC_DEF0, 1'b1, 1);
        idle_cycles("rst_mid_next_after", 1);
    endtask

    task automatic test_trunc();
        run_store("trunc_half", 32'h0000_0700, 32'hABCD_1234, 1'b0, 0);
        idle_cycles("trunc_half_after", 1);
        run_store("trunc_word", 32'h0000_0710, 32'hABCD_1234, 1'b1, 0);
        idle_cycles("trunc_word_after", 1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_store($sformatf("rand%0d", i), $urandom, $urandom, 1'($urandom),
                      int'($urandom_range(0, 3)));
            idle_cycles($sformatf("rand%0d_gap", i), int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_halfword();
        test_word_delayed();
        test_addr_edges();
        test_back_to_back();
        test_reset_mid();
        test_trunc();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
